// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bus bundle for alu_arbiter: two requesters, the shared ALU, one response.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [4:0]       req0_opcode;
    logic [4:0]       req0_shamt;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [4:0]       req1_opcode;
    logic [4:0]       req1_shamt;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic [4:0]       alu_opcode;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ne;
    logic             alu_lt;
    logic             alu_ovf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_ne;
    logic             rsp_lt;
    logic             rsp_ovf;

    modport slave (
        input  req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
        output req1_ready,
        output alu_opcode, alu_shamt, alu_a, alu_b,
        input  alu_result, alu_ne, alu_lt, alu_ovf,
        output rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_opcode, req0_shamt, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_opcode, req1_shamt, req1_a, req1_b,
        input  req1_ready,
        input  alu_opcode, alu_shamt, alu_a, alu_b,
        output alu_result, alu_ne, alu_lt, alu_ovf,
        input  rsp_valid, rsp_id, rsp_result, rsp_ne, rsp_lt, rsp_ovf,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters,
// with registered operands and a single id-tagged response channel.
module alu_arbiter #(
    parameter int WIDTH     = 32,
    parameter bit LAST_INIT = 1'b1
) (
    input logic        clock,
    input logic        reset,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic             last_grant;
    logic             id_reg;
    logic             grant;
    logic [4:0]       op_reg;
    logic [4:0]       sh_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
        else if (bus.req1_valid)              grant = 1'b1;
    end

    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !grant;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid &&  grant;
    assign bus.rsp_valid  = (state == RESP);

    assign bus.alu_opcode = op_reg;
    assign bus.alu_shamt  = sh_reg;
    assign bus.alu_a      = a_reg;
    assign bus.alu_b      = b_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= LAST_INIT;
            id_reg         <= 1'b0;
            op_reg         <= '0;
            sh_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_ne     <= 1'b0;
            bus.rsp_lt     <= 1'b0;
            bus.rsp_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        op_reg     <= grant ? bus.req1_opcode : bus.req0_opcode;
                        sh_reg     <= grant ? bus.req1_shamt  : bus.req0_shamt;
                        a_reg      <= grant ? bus.req1_a      : bus.req0_a;
                        b_reg      <= grant ? bus.req1_b      : bus.req0_b;
                        id_reg     <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    bus.rsp_result <= bus.alu_result;
                    bus.rsp_ne     <= bus.alu_ne;
                    bus.rsp_lt     <= bus.alu_lt;
                    bus.rsp_ovf    <= bus.alu_ovf;
                    bus.rsp_id     <= id_reg;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized checks of alu_arbiter against an ALU model and a round-robin reference.
module tb_alu_arbiter;
    localparam int W = 32;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   last;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W), .LAST_INIT(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Returns {ovf, lt, ne, result} of the ALU operation.
    function automatic logic [W+2:0] ref_op(input logic [4:0] op, input logic [4:0] sh,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         ovf;
        ovf = 1'b0;
        case (op)
            5'd1: begin
                r   = a - b;
                ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a << sh;
            5'd5: r = $unsigned($signed(a) >>> sh);
            default: begin
                r   = a + b;
                ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
        endcase
        return {ovf, ($signed(a) < $signed(b)), (a != b), r};
    endfunction

    always_comb begin
        {bus.alu_ovf, bus.alu_lt, bus.alu_ne, bus.alu_result} =
            ref_op(bus.alu_opcode, bus.alu_shamt, bus.alu_a, bus.alu_b);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic v, input logic [4:0] op, input logic [4:0] sh,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_opcode = op; bus.req0_shamt = sh;
            bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_opcode = op; bus.req1_shamt = sh;
            bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic chk_rsp(input string tag, input int id, input logic [4:0] op, input logic [4:0] sh,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W+2:0] e;
        e = ref_op(op, sh, a, b);
        chk({tag, ".valid"}, bus.rsp_valid, 1);
        chk({tag, ".id"}, bus.rsp_id, id[0]);
        chk({tag, ".result"}, bus.rsp_result, e[W-1:0]);
        chk({tag, ".flags"}, {bus.rsp_ovf, bus.rsp_lt, bus.rsp_ne}, e[W+2:W]);
    endtask

    task automatic chk_ready(input string tag, input logic r0, input logic r1);
        chk({tag, ".rdy0"}, bus.req0_ready, r0);
        chk({tag, ".rdy1"}, bus.req1_ready, r1);
    endtask

    // One isolated operation from requester id with rsp_ready held high.
    task automatic run_op(input string tag, input int id, input logic [4:0] op, input logic [4:0] sh,
                          input logic [W-1:0] a, input logic [W-1:0] b);
        set_req(id, 1'b1, op, sh, a, b);
        #1;
        chk_ready({tag, ".acc"}, id == 0, id == 1);
        step();
        set_req(id, 1'b0, op, sh, a, b);
        chk({tag, ".exec_op"}, bus.alu_opcode, op);
        chk({tag, ".exec_ab"}, {bus.alu_a, bus.alu_b}, {a, b});
        chk({tag, ".exec_vld"}, bus.rsp_valid, 0);
        step();
        chk_rsp(tag, id, op, sh, a, b);
        step();
        chk({tag, ".done"}, bus.rsp_valid, 0);
        last = id;
    endtask

    initial begin
        logic [W-1:0] hold;
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b0, 5'd0, 5'd0, '0, '0);
        set_req(1, 1'b0, 5'd0, 5'd0, '0, '0);
        last = 1;

        // Reset values, then reset hits mid-EXEC
        #12;
        chk("rst.vld", bus.rsp_valid, 0);
        chk("rst.res", bus.rsp_result, 0);
        chk("rst.alu_a", bus.alu_a, 0);
        reset = 1'b1;
        set_req(0, 1'b1, 5'd0, 5'd0, 32'd100, 32'd23);
        #1;
        chk_ready("rst.pre", 1, 0);
        step();
        set_req(0, 1'b0, 5'd0, 5'd0, 32'd100, 32'd23);
        chk("rst.exec_a", bus.alu_a, 100);
        #2 reset = 1'b0;
        #1;
        chk("rst.mid_vld", bus.rsp_valid, 0);
        chk_ready("rst.mid", 0, 0);
        chk("rst.mid_a", bus.alu_a, 0);
        chk("rst.mid_id", bus.rsp_id, 0);
        #3 reset = 1'b1;
        set_req(0, 1'b1, 5'd2, 5'd0, 32'hFF, 32'h0F);
        set_req(1, 1'b1, 5'd3, 5'd0, 32'hA0, 32'h0A);
        #1;
        chk_ready("rst.first", 1, 0);
        step();
        set_req(0, 1'b0, 5'd2, 5'd0, 32'hFF, 32'h0F);
        set_req(1, 1'b0, 5'd3, 5'd0, 32'hA0, 32'h0A);
        chk("rst.first_a", bus.alu_a, 32'hFF);
        step();
        chk_rsp("rst.first", 0, 5'd2, 5'd0, 32'hFF, 32'h0F);
        step();
        last = 0;

        // Single ADD
        run_op("add", 0, 5'd0, 5'd0, 32'd7, 32'd5);
        // Overflow and SRA from requester 1
        run_op("ovf", 1, 5'd0, 5'd0, 32'h7FFFFFFF, 32'd1);
        run_op("sra", 1, 5'd5, 5'd31, 32'h80000000, 32'd0);

        // Contention: alternating 0,1,0
        set_req(0, 1'b1, 5'd1, 5'd0, 32'd3, 32'd9);
        set_req(1, 1'b1, 5'd4, 5'd4, 32'd1, 32'd0);
        for (int k = 0; k < 3; k++) begin
            int e;
            e = k % 2;
            #1;
            chk_ready($sformatf("cont%0d.acc", k), e == 0, e == 1);
            step();
            chk_ready($sformatf("cont%0d.exec", k), 0, 0);
            chk($sformatf("cont%0d.op", k), bus.alu_opcode, (e == 0) ? 1 : 4);
            step();
            chk_ready($sformatf("cont%0d.resp", k), 0, 0);
            if (e == 0) begin
                chk_rsp($sformatf("cont%0d", k), 0, 5'd1, 5'd0, 32'd3, 32'd9);
                chk($sformatf("cont%0d.sub", k), {bus.rsp_lt, bus.rsp_result}, {1'b1, 32'hFFFFFFFA});
            end else begin
                chk_rsp($sformatf("cont%0d", k), 1, 5'd4, 5'd4, 32'd1, 32'd0);
                chk($sformatf("cont%0d.sll", k), bus.rsp_result, 16);
            end
            step();
        end
        set_req(0, 1'b0, 5'd0, 5'd0, '0, '0);
        set_req(1, 1'b0, 5'd0, 5'd0, '0, '0);
        last = 0;

        // Back-pressure with requester 1 waiting
        set_req(0, 1'b1, 5'd2, 5'd0, 32'hF0F0, 32'hFF00);
        step();
        set_req(0, 1'b0, 5'd2, 5'd0, 32'hF0F0, 32'hFF00);
        bus.rsp_ready = 1'b0;
        step();
        set_req(1, 1'b1, 5'd3, 5'd0, 32'h12, 32'h21);
        #1;
        hold = bus.rsp_result;
        chk("bp.hold_val", hold, 32'hF000);
        for (int i = 0; i < 5; i++) begin
            chk_rsp($sformatf("bp%0d", i), 0, 5'd2, 5'd0, 32'hF0F0, 32'hFF00);
            chk_ready($sformatf("bp%0d", i), 0, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        chk_rsp("bp.rel", 0, 5'd2, 5'd0, 32'hF0F0, 32'hFF00);
        step();
        chk_ready("bp.idle", 0, 1);
        step();
        set_req(1, 1'b0, 5'd3, 5'd0, 32'h12, 32'h21);
        chk("bp.exec_a", bus.alu_a, 32'h12);
        step();
        chk_rsp("bp.r1", 1, 5'd3, 5'd0, 32'h12, 32'h21);
        step();
        last = 1;

        // Idle: nothing moves
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("idle%0d.alu", i), {bus.alu_opcode, bus.alu_a, bus.alu_b}, {5'd3, 32'h12, 32'h21});
            chk($sformatf("idle%0d.vld", i), bus.rsp_valid, 0);
            step();
        end

        // Withdrawn request during RESP is never served
        set_req(1, 1'b1, 5'd0, 5'd0, 32'd40, 32'd2);
        bus.rsp_ready = 1'b0;
        step();
        set_req(1, 1'b0, 5'd0, 5'd0, 32'd40, 32'd2);
        step();
        set_req(0, 1'b1, 5'd1, 5'd0, 32'd99, 32'd1);
        #1;
        chk_ready("wd.pulse", 0, 0);
        step();
        set_req(0, 1'b0, 5'd1, 5'd0, 32'd99, 32'd1);
        bus.rsp_ready = 1'b1;
        chk_rsp("wd.rsp", 1, 5'd0, 5'd0, 32'd40, 32'd2);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wd%0d.vld", i), bus.rsp_valid, 0);
            chk($sformatf("wd%0d.alu_a", i), bus.alu_a, 40);
            step();
        end
        last = 1;

        // Randomized operations against the round-robin reference
        for (int it = 0; it < 40; it++) begin
            logic         v0, v1;
            int           g, w;
            logic [4:0]   op [2];
            logic [4:0]   sh [2];
            logic [W-1:0] a [2];
            logic [W-1:0] b [2];
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            for (int r = 0; r < 2; r++) begin
                op[r] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
                sh[r] = 5'($urandom_range(0, 31));
                a[r]  = $urandom;
                b[r]  = ($urandom_range(0, 4) == 0) ? a[r] : $urandom;
            end
            set_req(0, v0, op[0], sh[0], a[0], b[0]);
            set_req(1, v1, op[1], sh[1], a[1], b[1]);
            #1;
            if (!v0 && !v1) begin
                chk_ready($sformatf("rnd%0d.none", it), 0, 0);
                step();
                chk($sformatf("rnd%0d.none_vld", it), bus.rsp_valid, 0);
            end else begin
                if (v0 && v1) g = 1 - last;
                else          g = v0 ? 0 : 1;
                chk_ready($sformatf("rnd%0d.acc", it), g == 0, g == 1);
                step();
                set_req(0, 1'b0, op[0], sh[0], a[0], b[0]);
                set_req(1, 1'b0, op[1], sh[1], a[1], b[1]);
                chk($sformatf("rnd%0d.alu", it), {bus.alu_opcode, bus.alu_shamt, bus.alu_a, bus.alu_b},
                    {op[g], sh[g], a[g], b[g]});
                step();
                w = $urandom_range(0, 2);
                bus.rsp_ready = (w == 0);
                chk_rsp($sformatf("rnd%0d", it), g, op[g], sh[g], a[g], b[g]);
                for (int j = 0; j < w; j++) begin
                    step();
                    if (j == w - 1) bus.rsp_ready = 1'b1;
                    chk_rsp($sformatf("rnd%0d.bp", it), g, op[g], sh[g], a[g], b[g]);
                end
                step();
                chk($sformatf("rnd%0d.done", it), bus.rsp_valid, 0);
                last = g;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
